// File: rtl/clock_div_gen.sv
// Multi-channel programmable clock/strobe generator.
// Each channel divides the system clock by a run-time period and switches config only at period boundaries.
module clock_div_gen #(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned DEF_PERIOD = 20,
    parameter int unsigned DEF_HIGH   = 10
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NUM_CH-1:0] enable,
    input  logic [NUM_CH-1:0] load,
    input  logic [CNT_W-1:0]  period_in,
    input  logic [CNT_W-1:0]  high_in,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] pend,
    output logic [NUM_CH-1:0] cfg_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    typedef struct packed {
        logic [CNT_W-1:0] period;
        logic [CNT_W-1:0] high;
    } cfg_t;

    localparam cfg_t DEF_CFG = '{period: CNT_W'(DEF_PERIOD), high: CNT_W'(DEF_HIGH)};

    // Load validation is shared: every channel sees the same period_in/high_in.
    logic load_ok_c;
    cfg_t load_cfg_c;

    assign load_ok_c  = (period_in >= CNT_W'(2)) && (high_in != '0) && (high_in < period_in);
    assign load_cfg_c = '{period: period_in, high: high_in};

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        state_e           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        cfg_t             cur_q, cur_d;
        cfg_t             nxt_q, nxt_d;
        logic             pend_q, pend_d;
        logic             clk_q, clk_d;
        logic             tick_q, tick_d;
        logic             err_q, err_d;
        logic             last_c;
        logic             take_c;

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
                cur_q   <= DEF_CFG;
                nxt_q   <= DEF_CFG;
                pend_q  <= 1'b0;
                clk_q   <= 1'b0;
                tick_q  <= 1'b0;
                err_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                cur_q   <= cur_d;
                nxt_q   <= nxt_d;
                pend_q  <= pend_d;
                clk_q   <= clk_d;
                tick_q  <= tick_d;
                err_q   <= err_d;
            end
        end

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            cur_d   = cur_q;
            nxt_d   = nxt_q;
            pend_d  = pend_q;
            clk_d   = 1'b0;
            tick_d  = 1'b0;
            take_c  = load[ch] && load_ok_c;
            err_d   = load[ch] && !load_ok_c;
            last_c  = (cnt_q == (cur_q.period - CNT_W'(1)));

            unique case (state_q)
                ST_IDLE: begin
                    cnt_d = '0;
                    // A value left pending by a load on the stopping edge is applied here.
                    if (pend_q) begin
                        cur_d  = nxt_q;
                        pend_d = 1'b0;
                    end
                    if (take_c) begin
                        cur_d = load_cfg_c;
                    end
                    if (enable[ch]) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN, ST_DRAIN: begin
                    if (last_c) begin
                        cnt_d = '0;
                        if (pend_q) begin
                            cur_d  = nxt_q;
                            pend_d = 1'b0;
                        end
                        state_d = enable[ch] ? ST_RUN : ST_IDLE;
                    end else begin
                        cnt_d   = cnt_q + CNT_W'(1);
                        state_d = enable[ch] ? ST_RUN : ST_DRAIN;
                    end
                    // Captured after the wrap update so a same-edge load waits one more period.
                    if (take_c) begin
                        nxt_d  = load_cfg_c;
                        pend_d = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase

            clk_d  = (state_d != ST_IDLE) && (cnt_d < cur_d.high);
            tick_d = (state_d == ST_RUN) && (cnt_d == '0);
        end

        assign clk_out[ch] = clk_q;
        assign tick[ch]    = tick_q;
        assign pend[ch]    = pend_q;
        assign cfg_err[ch] = err_q;
    end

endmodule
